// File: rtl/branch_predictor.sv
// BTB-style branch predictor: direct-mapped table of tagged targets with saturating counters.
// Optional return-address stack enabled by defining BP_RAS_EN.
module branch_predictor #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ENTRIES   = 64,
    parameter int unsigned TAG_BITS  = 10,
    parameter int unsigned CNT_BITS  = 2,
    parameter int unsigned RAS_DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] if_pc,
    output logic            predict_taken,
    output logic [XLEN-1:0] predict_target,
    input  logic            ex_update_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_is_branch,
    input  logic            ex_is_jump,
    input  logic            ex_is_call,
    input  logic            ex_is_ret,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target
);

    localparam int unsigned IDX = $clog2(ENTRIES);
    localparam logic [CNT_BITS-1:0] CNT_WEAK = CNT_BITS'(1) << (CNT_BITS - 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        T_COND = 2'd0,
        T_JUMP = 2'd1,
        T_RET  = 2'd2
    } br_type_e;

    logic                valid_q [ENTRIES];
    logic [TAG_BITS-1:0] tag_q   [ENTRIES];
    logic [XLEN-1:0]     tgt_q   [ENTRIES];
    br_type_e            type_q  [ENTRIES];
    logic [CNT_BITS-1:0] cnt_q   [ENTRIES];

    logic [IDX-1:0]      rd_idx, wr_idx;
    logic [TAG_BITS-1:0] rd_tag, wr_tag;
    logic                rd_hit, wr_hit, upd_en, alloc;
    br_type_e            wr_type;
    logic [CNT_BITS-1:0] cnt_d;

    assign rd_idx = if_pc[IDX+1:2];
    assign rd_tag = if_pc[IDX+2 +: TAG_BITS];
    assign wr_idx = ex_pc[IDX+1:2];
    assign wr_tag = ex_pc[IDX+2 +: TAG_BITS];

    assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    assign upd_en = ex_update_valid && (ex_is_branch || ex_is_jump);
    assign alloc  = upd_en && !wr_hit && (ex_is_jump || (ex_is_branch && ex_taken));

    always_comb begin
        wr_type = T_COND;
        if (ex_is_ret) begin
            wr_type = T_RET;
        end else if (ex_is_jump) begin
            wr_type = T_JUMP;
        end
    end

    always_comb begin
        cnt_d = cnt_q[wr_idx];
        if (ex_taken) begin
            if (cnt_q[wr_idx] != CNT_MAX) cnt_d = cnt_q[wr_idx] + CNT_BITS'(1);
        end else begin
            if (cnt_q[wr_idx] != '0) cnt_d = cnt_q[wr_idx] - CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= CNT_WEAK;
            end
        end else if (upd_en) begin
            if (wr_hit) begin
                if (type_q[wr_idx] == T_COND) begin
                    cnt_q[wr_idx] <= cnt_d;
                    if (ex_taken) tgt_q[wr_idx] <= ex_target;
                end else begin
                    tgt_q[wr_idx] <= ex_target;
                end
            end else if (alloc) begin
                valid_q[wr_idx] <= 1'b1;
                tag_q[wr_idx]   <= wr_tag;
                tgt_q[wr_idx]   <= ex_target;
                type_q[wr_idx]  <= wr_type;
                cnt_q[wr_idx]   <= CNT_WEAK;
            end
        end
    end

`ifdef BP_RAS_EN
    localparam int unsigned RP = $clog2(RAS_DEPTH);
    localparam logic [RP:0] RAS_FULL = (RP+1)'(RAS_DEPTH);

    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [RP-1:0]   ras_ptr_q;
    logic [RP:0]     ras_cnt_q;
    logic [RP-1:0]   ras_top_ptr;
    logic [XLEN-1:0] ras_top, ret_addr;

    // ras_ptr_q is the next free slot; the top lives one below, wrapping circularly.
    assign ras_top_ptr = ras_ptr_q - RP'(1);
    assign ras_top     = ras_q[ras_top_ptr];
    assign ret_addr    = ex_pc + XLEN'(4);

    always_ff @(posedge clk) begin
        if (reset) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else if (upd_en) begin
            if (ex_is_call && !ex_is_ret) begin
                ras_ptr_q <= ras_ptr_q + RP'(1);
                if (ras_cnt_q != RAS_FULL) ras_cnt_q <= ras_cnt_q + (RP+1)'(1);
            end else if (ex_is_ret && !ex_is_call && ras_cnt_q != '0) begin
                ras_ptr_q <= ras_top_ptr;
                ras_cnt_q <= ras_cnt_q - (RP+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && upd_en && ex_is_call) begin
            if (ex_is_ret) begin
                ras_q[ras_top_ptr] <= ret_addr;
            end else begin
                ras_q[ras_ptr_q] <= ret_addr;
            end
        end
    end
`endif

    always_comb begin
        predict_taken  = rd_hit && (type_q[rd_idx] != T_COND || cnt_q[rd_idx][CNT_BITS-1]);
        predict_target = '0;
        if (predict_taken) begin
            predict_target = tgt_q[rd_idx];
`ifdef BP_RAS_EN
            if (type_q[rd_idx] == T_RET && ras_cnt_q != '0) predict_target = ras_top;
`endif
        end
    end

    logic unused_bits;
    assign unused_bits = ^{if_pc[1:0], if_pc[XLEN-1:IDX+2+TAG_BITS],
                           ex_pc[1:0], ex_pc[XLEN-1:IDX+2+TAG_BITS], ex_is_call};

endmodule
